// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types and constants for the fetch redirect controller: FSM states,
// redirect source codes, PC width and small helpers.
package fetch_ctrl_pkg;

   localparam int PC_W    = 16;
   localparam int TIMER_W = 4;
   localparam int CNT_W   = 8;

   typedef logic [PC_W-1:0]    pc_t;
   typedef logic [TIMER_W-1:0] timer_t;
   typedef logic [CNT_W-1:0]   cnt_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      REDIR = 2'd2
   } fsm_state_t;

   // Numeric order doubles as program-order age: a larger code is older.
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_DEC  = 2'd1,
      SRC_EX   = 2'd2,
      SRC_WB   = 2'd3
   } src_t;

   function automatic cnt_t sat_inc(input cnt_t v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Bundle between the back-end pipeline, the redirect controller and FetchStage.
// master = pipeline/driver side, slave = fetch_redirect_ctrl.
interface fetch_redirect_ctrl_if;
   import fetch_ctrl_pkg::*;

   // Redirect requests are single-cycle valid pulses with no ready: a request
   // is either accepted on the edge it is sampled or dropped for good. The
   // stall output is the only back-pressure and it applies to FetchStage.
   logic       wbR0w;
   pc_t        wbR0d;
   logic       exRedirect;
   pc_t        exTarget;
   logic       decRedirect;
   pc_t        decTarget;
   logic       dqFull;
   logic       extStall;

   logic       stall;
   logic       flush;
   logic       R0w;
   pc_t        R0d;
   logic [1:0] src;
   cnt_t       redirCnt;

   fsm_state_t dbg_state;
   timer_t     dbg_timer;

   modport master (
      output wbR0w, wbR0d, exRedirect, exTarget, decRedirect, decTarget,
             dqFull, extStall,
      input  stall, flush, R0w, R0d, src, redirCnt, dbg_state, dbg_timer
   );

   modport slave (
      input  wbR0w, wbR0d, exRedirect, exTarget, decRedirect, decTarget,
             dqFull, extStall,
      output stall, flush, R0w, R0d, src, redirCnt, dbg_state, dbg_timer
   );

endinterface

// File: rtl/fetch_redirect_ctrl_arb.sv
// Combinational redirect arbiter: picks the oldest request and decides whether
// it may start or replace a flush/redirect sequence.
module redirect_arb
   import fetch_ctrl_pkg::*;
(
   input  logic busy,
   input  src_t cur_src,
   input  logic wb_req,
   input  pc_t  wb_tgt,
   input  logic ex_req,
   input  pc_t  ex_tgt,
   input  logic dec_req,
   input  pc_t  dec_tgt,
   output logic accept,
   output pc_t  new_tgt,
   output src_t new_src
);

   // Inside a sequence only an older source can interrupt; anything equal or
   // younger belongs to the squashed path. Decode never interrupts.
   always_comb begin
      accept  = 1'b0;
      new_tgt = '0;
      new_src = SRC_NONE;
      if (wb_req) begin
         if (!busy || (cur_src < SRC_WB)) begin
            accept  = 1'b1;
            new_tgt = wb_tgt;
            new_src = SRC_WB;
         end
      end else if (ex_req) begin
         if (!busy || (cur_src < SRC_EX)) begin
            accept  = 1'b1;
            new_tgt = ex_tgt;
            new_src = SRC_EX;
         end
      end else if (dec_req) begin
         if (!busy) begin
            accept  = 1'b1;
            new_tgt = dec_tgt;
            new_src = SRC_DEC;
         end
      end
   end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Sequencing controller for FetchStage: flush for FLUSH_CYCLES, then a one-cycle
// PC load, for reset and for every accepted redirect. FLUSH_CYCLES must be 1..15.
module fetch_redirect_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int  FLUSH_CYCLES = 2,
   parameter pc_t RESET_PC     = 16'h0000
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   fetch_redirect_ctrl_if.slave  bus
);

   localparam timer_t FLUSH_LOAD = TIMER_W'(FLUSH_CYCLES);

   fsm_state_t state_q;
   timer_t     timer_q;
   pc_t        target_q;
   src_t       src_q;
   logic       flush_q;
   logic       r0w_q;
   pc_t        r0d_q;
   cnt_t       cnt_q;
   logic       run_q;

   logic       busy;
   logic       accept;
   pc_t        arb_tgt;
   src_t       arb_src;

   assign busy = (state_q != RUN);

   redirect_arb u_arb (
      .busy    (busy),
      .cur_src (src_q),
      .wb_req  (bus.wbR0w),
      .wb_tgt  (bus.wbR0d),
      .ex_req  (bus.exRedirect),
      .ex_tgt  (bus.exTarget),
      .dec_req (bus.decRedirect),
      .dec_tgt (bus.decTarget),
      .accept  (accept),
      .new_tgt (arb_tgt),
      .new_src (arb_src)
   );

   // Outputs are registered alongside the next state so they always match it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= FLUSH;
         timer_q  <= FLUSH_LOAD;
         target_q <= RESET_PC;
         src_q    <= SRC_NONE;
         flush_q  <= 1'b1;
         r0w_q    <= 1'b0;
         r0d_q    <= RESET_PC;
         cnt_q    <= '0;
         run_q    <= 1'b0;
      end else if (accept) begin
         // Accepting from REDIR leaves this cycle's PC load in place; the
         // new sequence ends with its own load that overrides it.
         state_q  <= FLUSH;
         timer_q  <= FLUSH_LOAD;
         target_q <= arb_tgt;
         src_q    <= arb_src;
         flush_q  <= 1'b1;
         r0w_q    <= 1'b0;
         cnt_q    <= sat_inc(cnt_q);
         run_q    <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               flush_q <= 1'b0;
               r0w_q   <= 1'b0;
               run_q   <= 1'b1;
            end
            FLUSH: begin
               if (timer_q <= TIMER_W'(1)) begin
                  state_q <= REDIR;
                  flush_q <= 1'b0;
                  r0w_q   <= 1'b1;
                  r0d_q   <= target_q;
               end else begin
                  timer_q <= timer_q - TIMER_W'(1);
               end
            end
            REDIR: begin
               state_q <= RUN;
               src_q   <= SRC_NONE;
               flush_q <= 1'b0;
               r0w_q   <= 1'b0;
               run_q   <= 1'b1;
            end
            default: begin
               state_q <= RUN;
               src_q   <= SRC_NONE;
               flush_q <= 1'b0;
               r0w_q   <= 1'b0;
               run_q   <= 1'b1;
            end
         endcase
      end
   end

   // Back-pressure is only forwarded while running; a sequence masks it.
   assign bus.stall     = run_q & (bus.dqFull | bus.extStall);
   assign bus.flush     = flush_q;
   assign bus.R0w       = r0w_q;
   assign bus.R0d       = r0d_q;
   assign bus.src       = src_q;
   assign bus.redirCnt  = cnt_q;
   assign bus.dbg_state = state_q;
   assign bus.dbg_timer = timer_q;

endmodule
